// File: rtl/gpio_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// gpio_cfg_sequencer
//
// Bit-bangs PL configuration commands onto the 8-bit GPIO bus. It accepts one
// command at a time. For shift targets, it drives the payload MSB-first on the
// shared sdata line. It toggles only the addressed serial clock, so the loads
// of the mask, select, cycle-count and mux shift registers never overlap.
// The pl_rst target produces a timed reset pulse instead.
//
// Ports
//   clk              fabric clock, rising edge
//   rst_n            asynchronous active-low reset
//   cmd_valid        command present
//   cmd_ready        command can be accepted (IDLE only)
//   cmd_target       GPIO bit to drive: 1 mask_clk, 2 sel_clk,
//                    3 cycle_count_clk, 4 mux_set_clk, 5 pl_rst
//   cmd_len          bit count (shift) or pulse length in cycles (pl_rst)
//   cmd_data         right-aligned payload; bit cmd_len-1 is shifted first
//   cmd_half_period  serial clock half period minus one
//   gpio_out         [0] sdata, [1] mask_clk, [2] sel_clk,
//                    [3] cycle_count_clk, [4] mux_set_clk, [5] pl_rst, [7:6] 0
//   busy             high whenever the sequencer is not idle
//   done             one-cycle pulse when a legal command completes
//   err              one-cycle pulse when an illegal command is rejected
// -----------------------------------------------------------------------------
module gpio_cfg_sequencer #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 9,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_target,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DIV_W-1:0]  cmd_half_period,
  output logic [7:0]        gpio_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Width of a bit index into the payload. Legal lengths keep the bit counter
  // below DATA_W, so the truncated index always addresses a real bit.
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] TGT_FIRST = 3'd1;
  localparam logic [2:0] TGT_RST   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_RSTP,
    ST_FIN,
    ST_ERR
  } state_t;

  // ---------------------------------------------------------------------------
  // State and captured command
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [2:0]         r_target;
  logic [DATA_W-1:0]  r_data;
  logic [DIV_W-1:0]   r_half;      // H-1; a phase ends when r_div reaches it
  logic [DIV_W-1:0]   r_div;       // cycles spent in the current phase
  logic [LEN_W-1:0]   r_bit;       // current bit index, or remaining pulse cycles

  // Registered outputs
  logic [7:0]         r_gpio;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_ready;

  // Next-state values
  state_t             w_state_nxt;
  logic [2:0]         w_target_nxt;
  logic [DATA_W-1:0]  w_data_nxt;
  logic [DIV_W-1:0]   w_half_nxt;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [LEN_W-1:0]   w_bit_nxt;
  logic [7:0]         w_gpio_nxt;
  logic [IDX_W-1:0]   w_bit_idx;
  logic               w_cmd_legal;
  logic               w_phase_end;

  assign w_cmd_legal = (cmd_target >= TGT_FIRST) && (cmd_target <= TGT_RST) &&
                       (cmd_len != '0) && (cmd_len <= LEN_W'(DATA_W));

  assign w_phase_end = (r_div == r_half);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement; a path that
  // left one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_data_nxt   = r_data;
    w_half_nxt   = r_half;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!w_cmd_legal) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_target_nxt = cmd_target;
            w_data_nxt   = cmd_data;
            w_half_nxt   = cmd_half_period;
            w_div_nxt    = '0;
            // Shift: index of the first (most significant) bit.
            // pl_rst: remaining high cycles after this one.
            w_bit_nxt    = cmd_len - LEN_W'(1);
            w_state_nxt  = (cmd_target == TGT_RST) ? ST_RSTP : ST_LOW;
          end
        end
      end

      ST_LOW: begin
        if (w_phase_end) begin
          w_div_nxt   = '0;
          w_state_nxt = ST_HIGH;
        end else begin
          w_div_nxt   = r_div + DIV_W'(1);
        end
      end

      ST_HIGH: begin
        if (w_phase_end) begin
          w_div_nxt = '0;
          if (r_bit == '0) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_bit_nxt   = r_bit - LEN_W'(1);
            w_state_nxt = ST_LOW;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      ST_RSTP: begin
        if (r_bit == '0) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_bit_nxt   = r_bit - LEN_W'(1);
        end
      end

      ST_FIN,
      ST_ERR: begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output is a flop and changes
  // in the same cycle as the state it describes.
  // ---------------------------------------------------------------------------
  assign w_bit_idx = w_bit_nxt[IDX_W-1:0];

  always_comb begin
    w_gpio_nxt = '0;
    unique case (w_state_nxt)
      ST_LOW: begin
        w_gpio_nxt[0] = w_data_nxt[w_bit_idx];
      end
      ST_HIGH: begin
        // sdata is held through the high phase; only the addressed clock rises.
        w_gpio_nxt[0]            = w_data_nxt[w_bit_idx];
        w_gpio_nxt[w_target_nxt] = 1'b1;
      end
      ST_RSTP: begin
        w_gpio_nxt[TGT_RST] = 1'b1;
      end
      default: w_gpio_nxt = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that all flops
  // update together from values sampled before the edge.
  // NOTE: the payload register is reset along with everything else. It is a
  // flop bank, not a RAM, and a defined value keeps sdata clean after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_data   <= '0;
      r_half   <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_gpio   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_data   <= w_data_nxt;
      r_half   <= w_half_nxt;
      r_div    <= w_div_nxt;
      r_bit    <= w_bit_nxt;
      r_gpio   <= w_gpio_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_FIN);
      r_err    <= (w_state_nxt == ST_ERR);
      r_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

  assign gpio_out  = r_gpio;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cmd_ready = r_ready;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpio_cfg_sequencer
//
// Directed bench for gpio_cfg_sequencer. Each command is issued at a falling
// edge and accepted on the next rising edge (edge 0). Cycle c is then sampled
// on the falling edge that follows edge c-1. Expected GPIO waveforms come from
// the cycle formulas of the block's timing description.
// -----------------------------------------------------------------------------
module tb_gpio_cfg_sequencer;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 9;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_target = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DIV_W-1:0]  cmd_half_period = '0;
  logic [7:0]        gpio_out;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent exec() call
  int                m_done_cyc;
  int                m_err_cyc;
  int                m_wave_err;
  int                m_rise;
  logic [DATA_W-1:0] m_cap;
  logic              m_busy1;
  logic              m_after_ok;

  gpio_cfg_sequencer #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_target      (cmd_target),
    .cmd_len         (cmd_len),
    .cmd_data        (cmd_data),
    .cmd_half_period (cmd_half_period),
    .gpio_out        (gpio_out),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] t, input logic [LEN_W-1:0] l,
                       input logic [DATA_W-1:0] d, input logic [DIV_W-1:0] h);
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_target      = t;
    cmd_len         = l;
    cmd_data        = d;
    cmd_half_period = h;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Issue one command, then follow it cycle by cycle until done/err or the
  // cycle budget runs out. The cycle after done/err is checked for idle.
  task automatic exec(input logic [2:0] t, input logic [LEN_W-1:0] l,
                      input logic [DATA_W-1:0] d, input logic [DIV_W-1:0] h,
                      input int limit);
    int                hh;
    int                total;
    int                ph;
    int                b;
    logic [7:0]        g;
    logic [7:0]        e;
    logic [7:0]        prev;
    logic              legal;
    logic [DATA_W-1:0] sh;
    legal = (t >= 3'd1) && (t <= 3'd5) && (l >= 1) && (l <= DATA_W);
    hh    = int'(h) + 1;
    total = 2 * int'(l) * hh;
    m_done_cyc = -1;
    m_err_cyc  = -1;
    m_wave_err = 0;
    m_rise     = 0;
    m_cap      = '0;
    m_busy1    = 1'b0;
    prev       = '0;
    issue(t, l, d, h);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      g = gpio_out;
      e = '0;
      if (legal && t == 3'd5) begin
        e = (c <= int'(l)) ? 8'h20 : 8'h00;
      end else if (legal && c <= total) begin
        ph   = (c - 1) / hh;
        b    = int'(l) - 1 - ph / 2;
        sh   = d >> b;
        e[0] = sh[0];
        e[t] = ph[0];
      end
      if (g !== e) m_wave_err++;
      if (legal && t != 3'd5 && g[t] && !prev[t]) begin
        m_rise++;
        m_cap = {m_cap[DATA_W-2:0], g[0]};
      end
      prev = g;
      if (c == 1) m_busy1 = busy;
      if (done && m_done_cyc < 0) m_done_cyc = c;
      if (err && m_err_cyc < 0) m_err_cyc = c;
      if (done || err) break;
    end
    @(negedge clk);
    m_after_ok = cmd_ready && !done && !err && (gpio_out == 8'h00);
  endtask

  initial begin : stim
    logic [DATA_W-1:0] rnd;
    logic [2:0]        ill_t [4];
    logic [LEN_W-1:0]  ill_l [4];
    logic [7:0]        b2b_exp [12];
    int                b2b_err;
    int                b2b_done1;
    int                b2b_done2;
    int                b2b_ready;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gpio", gpio_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_idle_outs", {gpio_out, busy, done, err}, 11'h000);

    // ---------------- select write ----------------
    exec(3'd2, 9'd16, 256'h0004, 8'd0, 60);
    check("sel_busy1", m_busy1, 1'b1);
    check("sel_wave", m_wave_err, 0);
    check("sel_pulses", m_rise, 16);
    check("sel_stream", m_cap, 256'h0004);
    check("sel_done_cyc", m_done_cyc, 33);
    check("sel_after", m_after_ok, 1'b1);

    // ---------------- cycle count write ----------------
    for (int i = 0; i < DATA_W / 32; i++) rnd[i*32 +: 32] = $urandom;
    exec(3'd3, 9'd256, rnd, 8'd3, 2200);
    check("cc_wave", m_wave_err, 0);
    check("cc_pulses", m_rise, 256);
    check("cc_stream", m_cap, rnd);
    check("cc_done_cyc", m_done_cyc, 2049);
    check("cc_after", m_after_ok, 1'b1);

    // ---------------- pl_rst pulse ----------------
    exec(3'd5, 9'd10, {DATA_W{1'b1}}, 8'd2, 50);
    check("rstp_wave", m_wave_err, 0);
    check("rstp_done_cyc", m_done_cyc, 11);
    check("rstp_after", m_after_ok, 1'b1);

    // ---------------- illegal commands ----------------
    ill_t = '{3'd0, 3'd6, 3'd2, 3'd2};
    ill_l = '{9'd16, 9'd16, 9'd0, 9'd257};
    for (int i = 0; i < 4; i++) begin
      exec(ill_t[i], ill_l[i], {DATA_W{1'b1}}, 8'd0, 20);
      check($sformatf("ill%0d_err_cyc", i), m_err_cyc, 1);
      check($sformatf("ill%0d_no_done", i), m_done_cyc, -1);
      check($sformatf("ill%0d_gpio", i), m_wave_err, 0);
      check($sformatf("ill%0d_ready_c2", i), m_after_ok, 1'b1);
    end

    // ---------------- reset mid-shift ----------------
    issue(3'd1, 9'd16, 256'hA5C3, 8'd0);
    repeat (9) @(negedge clk);          // cycle 9: first half of bit 5
    check("mrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_gpio_async", gpio_out, 8'h00);
    check("mrst_busy_async", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", {cmd_ready, done, err}, 3'b100);
    exec(3'd1, 9'd16, 256'h8001, 8'd0, 60);
    check("mrst_new_wave", m_wave_err, 0);
    check("mrst_new_stream", m_cap, 256'h8001);
    check("mrst_new_done", m_done_cyc, 33);

    // ---------------- back-to-back ----------------
    b2b_exp = '{8'h01, 8'h11, 8'h00, 8'h00, 8'h01, 8'h03,
                8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    b2b_err   = 0;
    b2b_done1 = -1;
    b2b_done2 = -1;
    b2b_ready = -1;
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_target      = 3'd4;
    cmd_len         = 9'd1;
    cmd_data        = 256'h1;
    cmd_half_period = 8'd0;
    @(posedge clk);
    #1;
    cmd_target = 3'd1;
    cmd_len    = 9'd2;
    cmd_data   = 256'h2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gpio_out !== b2b_exp[c-1]) b2b_err++;
      if (done && b2b_done1 < 0) b2b_done1 = c;
      else if (done && b2b_done2 < 0) b2b_done2 = c;
      if (cmd_ready && b2b_ready < 0) b2b_ready = c;
      if (c == 5) cmd_valid = 1'b0;
    end
    check("b2b_wave", b2b_err, 0);
    check("b2b_done1", b2b_done1, 3);
    check("b2b_ready", b2b_ready, 4);
    check("b2b_done2", b2b_done2, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_sequencer.md
# gpio_cfg_sequencer

Sequences the PL configuration GPIO bus: accepts one configuration command at a time and bit-bangs it onto the shared `sdata` line plus the addressed serial clock line (`mask_clk`, `sel_clk`, `cycle_count_clk`, `mux_set_clk`). It also generates timed `pl_rst` pulses. The block sits between the PS-side command source (AXI-lite register bank) and the 8-bit GPIO bus. It serializes register loads for the per-channel masking, one-hot select, cycle-count and mux shift registers, so that they never overlap on the shared data line.

## Interface
Parameters:
- `DATA_W`, 256, maximum shift length in bits; sized for the 256-bit cycle-count register.
- `LEN_W`, 9, width of the length field; must satisfy 2^`LEN_W` > `DATA_W`.
- `DIV_W`, 8, width of the half-period divider field.

Ports:
- `clk`  in  1  fabric clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_target`  in  3  GPIO bit index of the line to drive: 1 `mask_clk`, 2 `sel_clk`, 3 `cycle_count_clk`, 4 `mux_set_clk`, 5 `pl_rst`.
- `cmd_len`  in  `LEN_W`  bit count (shift targets) or pulse length in cycles (`pl_rst`); legal range 1..`DATA_W`.
- `cmd_data`  in  `DATA_W`  shift payload, right-aligned; bit `cmd_len`-1 is shifted first.
- `cmd_half_period`  in  `DIV_W`  serial clock half period minus one.
- `gpio_out`  out  8  GPIO bus: [0] `sdata`, [1] `mask_clk`, [2] `sel_clk`, [3] `cycle_count_clk`, [4] `mux_set_clk`, [5] `pl_rst`, [7:6] tied 0.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a legal command completes.
- `err`  out  1  one-cycle pulse when an illegal command is rejected.

## Operation
- States: IDLE, LOW, HIGH, RSTP, FIN, ERR.
- Handshake: a command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both high.
  - At acceptance, target, length, data, and H = `cmd_half_period`+1 are captured.
  - Inputs are ignored at all other times.
- Illegal command: target in {0, 6, 7}, `cmd_len`=0, or `cmd_len`>`DATA_W`.
  - IDLE goes to ERR for one cycle with `err`=1.
  - No GPIO line toggles; `done` is not pulsed.
  - ERR then returns to IDLE.
- Shift targets (1–4):
  - IDLE goes to LOW with bit index i = len-1.
  - LOW lasts H cycles: `sdata` = data[i], addressed clock = 0.
  - HIGH lasts H cycles: `sdata` = data[i] (held), addressed clock = 1.
  - On HIGH exit: if i=0, go to FIN; otherwise decrement i and go to LOW.
  - Data is MSB-first; downstream registers sample on the rising edge of their clock.
- `pl_rst` target (5): IDLE goes to RSTP; `gpio_out[5]`=1 for exactly `cmd_len` cycles; then FIN.
- FIN lasts one cycle: all `gpio_out` = 0 and `done`=1; then IDLE.
- Only the addressed line is ever driven high. Non-addressed clock lines and `pl_rst` stay 0.
- `sdata` is 0 in IDLE, FIN, ERR and RSTP.
- Divider and bit counters are internal, width `DIV_W` and `LEN_W`; neither wraps in legal operation.

## Timing
- Reset (async assert, synchronous release on `clk`):
  - state IDLE.
  - `gpio_out`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1 (first cycle after release).
  - All counters 0.
- Reset asserted mid-command: outputs are forced to 0 immediately and the command is discarded. No `done` or `err` pulse follows.
- All outputs are registered. For a command accepted at edge 0:
  - Shift target, N bits: `busy`=1 and the first LOW cycle start in cycle 1. Shifting occupies cycles 1..2·N·H. FIN (`done`=1) is cycle 2·N·H+1. `cmd_ready`=1 again in cycle 2·N·H+2.
  - `pl_rst`, length L: `pl_rst` is high in cycles 1..L; FIN is cycle L+1.
  - Illegal command: `err` is high in cycle 1; `cmd_ready` returns in cycle 2.
- `sdata` and the clock falling edge change in the same cycle (LOW entry). `sdata` is stable H cycles before and H cycles after each rising edge.
- Back-to-back commands: the minimum gap is the single FIN or ERR cycle plus the IDLE acceptance cycle.

## Test plan
- Select write:
  - Stimulus: target=2, len=16, data=16'h0004, half_period=0.
  - Required: 16 `sel_clk` pulses, 1 cycle low / 1 cycle high each.
  - Required: `sdata` high only during the 14th pulse.
  - Required: `done` in cycle 33; other GPIO lines 0 throughout.
- Cycle count write:
  - Stimulus: target=3, len=256, random data, half_period=3.
  - Required: captured serial stream equals data, MSB-first.
  - Required: each half period is 4 cycles; `done` in cycle 2049.
- `pl_rst` pulse:
  - Stimulus: target=5, len=10.
  - Required: `gpio_out[5]` high in cycles 1–10, `done` in cycle 11, `sdata` 0 throughout.
- Illegal commands:
  - Stimulus: target=0, target=6, len=0, and len=257, each applied in turn.
  - Required: each gives `err` for 1 cycle, no GPIO activity, and `cmd_ready` in cycle 2.
- Reset mid-shift:
  - Stimulus: deassert `rst_n` during bit 5 of a mask write (target=1, len=16).
  - Required: `gpio_out`=0 asynchronously and `busy`=0.
  - Required: after release, a new command executes normally from its first bit.
- Back-to-back:
  - Stimulus: `cmd_valid` held high with queued mux-set (target=4, len=1) and mask (target=1, len=2) commands.
  - Required: second acceptance exactly 2 cycles after the first `done`.
  - Required: no overlap of `mux_set_clk` and `mask_clk` activity.
